// File: rtl/mem_sram_pkg.sv
// Shared types and helpers for the MEM-stage SRAM responder.
// FSM state encoding, default timing/base constants and the byte-to-halfword address map.
package mem_sram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam int unsigned WAIT_CYCLES_DEF = 3;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;

  // Halfword index {w, hi} where w = (addr - base) >> 2.
  function automatic logic [31:0] half_index(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic        hi
  );
    return (((addr - base) >> 2) << 1) | {31'd0, hi};
  endfunction

  // Word index w = (addr - base) >> 2.
  function automatic logic [29:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return 30'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/mem_sram_wait_counter.sv
// Wait-state counter for one 16-bit SRAM half access.
// Ports: clk, rst (sync, active-high), clr_i (force 0), en_i (count up),
//   tc_o (count == WAIT_CYCLES-1), tc_next_o (count == WAIT_CYCLES-2).
module sram_wait_counter
  import mem_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic tc_next_o
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(WAIT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o      = (cnt_q == LAST);
  // Lets the FSM register we_n for the cycle after this one.
  assign tc_next_o = (cnt_q == PRE);

endmodule

// File: rtl/mem_sram_responder.sv
// MEM-stage data-memory responder: one 32-bit access as two 16-bit SRAM halves.
// Ports: clk, rst, MEM_R_EN/MEM_W_EN/address/write_data from MEM, read_data/ready back,
//   sram_addr/sram_dq_out/sram_dq_in/sram_dq_oe/sram_we_n to the pads.
// Optional one-entry read buffer: define SRAM_READ_BUF_EN.
module mem_sram_responder
  import mem_sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_e st_q, st_d;

  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] wdh_q, wdh_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;
  logic [31:0] rd_q, rd_d;

  logic tc, tc_nx, cnt_clr, cnt_en;
  logic hit;
  logic [SRAM_ADDR_W-1:0] lo_addr;

  assign lo_addr =
    SRAM_ADDR_W'(half_index(address, BASE_ADDR, 1'b0));

`ifdef SRAM_READ_BUF_EN
  logic        bv_q, bv_d;
  logic [29:0] bw_q, bw_d;
  logic [31:0] bd_q, bd_d;
  logic [29:0] word_q, word_d;
  logic [29:0] req_word;

  assign req_word = word_index(address, BASE_ADDR);
  assign hit = (st_q == S_IDLE) && MEM_R_EN && !MEM_W_EN
            && bv_q && (bw_q == req_word);
  assign read_data = hit ? bd_q : rd_q;
`else
  assign hit = 1'b0;
  assign read_data = rd_q;
`endif

  assign ready = (st_q == S_DONE)
              || ((st_q == S_IDLE)
                  && ((!MEM_R_EN && !MEM_W_EN) || hit));

  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_o     (tc),
    .tc_next_o(tc_nx)
  );

  // Outputs are computed for the next cycle so the pads are glitch-free.
  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    lo_d    = lo_q;
    wdh_d   = wdh_q;
    rd_d    = rd_q;
    oe_d    = 1'b0;
    we_n_d  = 1'b1;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
`ifdef SRAM_READ_BUF_EN
    bv_d   = bv_q;
    bw_d   = bw_q;
    bd_d   = bd_q;
    word_d = word_q;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (MEM_W_EN) begin
          st_d   = S_WR_LO;
          addr_d = lo_addr;
          dq_d   = write_data[15:0];
          wdh_d  = write_data[31:16];
          oe_d   = 1'b1;
          we_n_d = 1'b0;
`ifdef SRAM_READ_BUF_EN
          bv_d   = 1'b0;
`endif
        end else if (MEM_R_EN && !hit) begin
          st_d   = S_RD_LO;
          addr_d = lo_addr;
`ifdef SRAM_READ_BUF_EN
          word_d = req_word;
`endif
        end
      end
      S_RD_LO: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        if (tc) begin
          lo_d   = sram_dq_in;
          st_d   = S_RD_HI;
          addr_d = {addr_q[SRAM_ADDR_W-1:1], 1'b1};
        end
      end
      S_RD_HI: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        if (tc) begin
          rd_d = {sram_dq_in, lo_q};
          st_d = S_DONE;
`ifdef SRAM_READ_BUF_EN
          bv_d = 1'b1;
          bw_d = word_q;
          bd_d = {sram_dq_in, lo_q};
`endif
        end
      end
      S_WR_LO: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        oe_d    = 1'b1;
        if (tc) begin
          st_d   = S_WR_HI;
          addr_d = {addr_q[SRAM_ADDR_W-1:1], 1'b1};
          dq_d   = wdh_q;
          we_n_d = 1'b0;
        end else begin
          // Release we_n on the last cycle so address/data hold past it.
          we_n_d = tc_nx;
        end
      end
      S_WR_HI: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        if (tc) begin
          st_d = S_DONE;
        end else begin
          oe_d   = 1'b1;
          we_n_d = tc_nx;
        end
      end
      S_DONE: begin
        st_d = S_IDLE;
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      addr_q <= '0;
      dq_q   <= '0;
      lo_q   <= '0;
      wdh_q  <= '0;
      oe_q   <= 1'b0;
      we_n_q <= 1'b1;
      rd_q   <= '0;
`ifdef SRAM_READ_BUF_EN
      bv_q   <= 1'b0;
      bw_q   <= '0;
      bd_q   <= '0;
      word_q <= '0;
`endif
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      dq_q   <= dq_d;
      lo_q   <= lo_d;
      wdh_q  <= wdh_d;
      oe_q   <= oe_d;
      we_n_q <= we_n_d;
      rd_q   <= rd_d;
`ifdef SRAM_READ_BUF_EN
      bv_q   <= bv_d;
      bw_q   <= bw_d;
      bd_q   <= bd_d;
      word_q <= word_d;
`endif
    end
  end

endmodule
